button_cmd_arbiter: RTL and testbench



---
 rtl/pet_pkg.sv | 36 +++
 rtl/rise_detect.sv | 19 +
 rtl/button_cmd_arbiter.sv | 142 ++++++++++++++
 tb/tb_button_cmd_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pet_pkg.sv
// Shared definitions for the button command arbiter and the pet state FSM:
// arbiter state encoding, test-code values and command priority indices.
package pet_pkg;

   localparam int unsigned CODE_W  = 4;
   localparam int unsigned NUM_CMD = 4;

   localparam logic [2:0] ST_IDLE         = 3'd0;
   localparam logic [2:0] ST_LOCK         = 3'd1;
   localparam logic [2:0] ST_TEST_HOLD    = 3'd2;
   localparam logic [2:0] ST_TEST_COLLECT = 3'd3;
   localparam logic [2:0] ST_TEST_COMMIT  = 3'd4;

   // Test codes select the pet FSM state forced in test mode
   localparam logic [CODE_W-1:0] TC_NONE    = 4'd0;
   localparam logic [CODE_W-1:0] TC_IDLE    = 4'd1;
   localparam logic [CODE_W-1:0] TC_NEUTRAL = 4'd2;
   localparam logic [CODE_W-1:0] TC_TIRED   = 4'd3;
   localparam logic [CODE_W-1:0] TC_SLEEP   = 4'd4;
   localparam logic [CODE_W-1:0] TC_HUNGRY  = 4'd5;
   localparam logic [CODE_W-1:0] TC_SAD     = 4'd6;
   localparam logic [CODE_W-1:0] TC_PLAYING = 4'd7;
   localparam logic [CODE_W-1:0] TC_BORED   = 4'd8;
   localparam logic [CODE_W-1:0] TC_DEATH   = 4'd9;

   // Bit index in the command vector; lower index wins arbitration
   localparam int unsigned CMD_AWAKE = 0;
   localparam int unsigned CMD_FEED  = 1;
   localparam int unsigned CMD_SLEEP = 2;
   localparam int unsigned CMD_PLAY  = 3;

   function automatic logic [CODE_W-1:0] code_sat_inc(input logic [CODE_W-1:0] code);
      return (code >= TC_DEATH) ? TC_DEATH : code + CODE_W'(1);
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for one debounced button; history preloads to 1 so a
// button held through reset does not fire.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic rise_c
);

   logic hist;

   always_ff @(posedge clk) begin
      if (rst) hist <= 1'b1;
      else     hist <= level;
   end

   assign rise_c = level & ~hist;

endmodule

// File: rtl/button_cmd_arbiter.sv
// Arbitrates debounced button edges into one-cycle pet commands and runs the
// long-press test-code entry handshake.
module button_cmd_arbiter #(
   parameter int unsigned HOLD_TEST = 50000000,
   parameter int unsigned PULSE_WIN = 75000000,
   parameter int unsigned LOCKOUT   = 12500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_sleep,
   input  logic       btn_awake,
   input  logic       btn_feed,
   input  logic       btn_play,
   input  logic       btn_test,
   output logic       cmd_sleep,
   output logic       cmd_awake,
   output logic       cmd_feed,
   output logic       cmd_play,
   output logic       test_mode,
   output logic [3:0] test_code,
   output logic       test_valid,
   output logic       busy
);
   import pet_pkg::*;

   localparam int unsigned MAX_HP  = (HOLD_TEST > PULSE_WIN) ? HOLD_TEST : PULSE_WIN;
   localparam int unsigned MAX_CNT = (MAX_HP > LOCKOUT) ? MAX_HP : LOCKOUT;
   localparam int unsigned TW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   logic rise_sleep, rise_awake, rise_feed, rise_play, rise_test;

   rise_detect u_rise_sleep (.clk(clk), .rst(rst), .level(btn_sleep), .rise_c(rise_sleep));
   rise_detect u_rise_awake (.clk(clk), .rst(rst), .level(btn_awake), .rise_c(rise_awake));
   rise_detect u_rise_feed  (.clk(clk), .rst(rst), .level(btn_feed),  .rise_c(rise_feed));
   rise_detect u_rise_play  (.clk(clk), .rst(rst), .level(btn_play),  .rise_c(rise_play));
   rise_detect u_rise_test  (.clk(clk), .rst(rst), .level(btn_test),  .rise_c(rise_test));

   logic [2:0]         state, state_nxt;
   logic [TW-1:0]      timer, timer_nxt;
   logic [NUM_CMD-1:0] cmd_q, cmd_nxt;
   logic [CODE_W-1:0]  code_q, code_nxt;
   logic               mode_q, mode_nxt;
   logic               valid_q, valid_nxt;
   logic               busy_q, busy_nxt;
   logic               any_action;

   assign any_action = rise_sleep | rise_awake | rise_feed | rise_play;

   // State, timer and all output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         timer   <= '0;
         cmd_q   <= '0;
         code_q  <= TC_NONE;
         mode_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         cmd_q   <= cmd_nxt;
         code_q  <= code_nxt;
         mode_q  <= mode_nxt;
         valid_q <= valid_nxt;
         busy_q  <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      cmd_nxt   = '0;
      code_nxt  = code_q;
      case (state)
         ST_IDLE: begin
            if (any_action) begin
               state_nxt = ST_LOCK;
               timer_nxt = TW'(LOCKOUT - 1);
               if (rise_awake)      cmd_nxt[CMD_AWAKE] = 1'b1;
               else if (rise_feed)  cmd_nxt[CMD_FEED]  = 1'b1;
               else if (rise_sleep) cmd_nxt[CMD_SLEEP] = 1'b1;
               else                 cmd_nxt[CMD_PLAY]  = 1'b1;
            end else if (rise_test) begin
               state_nxt = ST_TEST_HOLD;
               timer_nxt = '0;
            end
         end
         ST_LOCK: begin
            if (timer == '0) state_nxt = ST_IDLE;
            else             timer_nxt = timer - TW'(1);
         end
         ST_TEST_HOLD: begin
            if (!btn_test) begin
               state_nxt = ST_IDLE;
               timer_nxt = '0;
            end else if (timer == TW'(HOLD_TEST - 1)) begin
               state_nxt = ST_TEST_COLLECT;
               code_nxt  = TC_NONE;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         ST_TEST_COLLECT: begin
            // Awake aborts and outranks a play pulse in the same cycle
            if (rise_awake) begin
               state_nxt = ST_IDLE;
               code_nxt  = TC_NONE;
               timer_nxt = '0;
            end else if (rise_play) begin
               code_nxt  = code_sat_inc(code_q);
               timer_nxt = TW'(PULSE_WIN - 1);
            end else if (code_q != TC_NONE) begin
               if (timer == '0) state_nxt = ST_TEST_COMMIT;
               else             timer_nxt = timer - TW'(1);
            end
         end
         ST_TEST_COMMIT: begin
            state_nxt = ST_LOCK;
            timer_nxt = TW'(LOCKOUT - 1);
         end
         default: begin
            state_nxt = ST_IDLE;
            timer_nxt = '0;
         end
      endcase
      mode_nxt  = (state_nxt == ST_TEST_COLLECT);
      valid_nxt = (state_nxt == ST_TEST_COMMIT);
      busy_nxt  = (state_nxt != ST_IDLE);
   end

   assign cmd_awake  = cmd_q[CMD_AWAKE];
   assign cmd_feed   = cmd_q[CMD_FEED];
   assign cmd_sleep  = cmd_q[CMD_SLEEP];
   assign cmd_play   = cmd_q[CMD_PLAY];
   assign test_mode  = mode_q;
   assign test_code  = code_q;
   assign test_valid = valid_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_button_cmd_arbiter.sv
// Scoreboard bench for button_cmd_arbiter: stimulus queues expected command
// and commit events, a monitor thread pops and compares them.
module tb_button_cmd_arbiter;

   localparam int unsigned HOLD_TEST = 8;
   localparam int unsigned PULSE_WIN = 16;
   localparam int unsigned LOCKOUT   = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_sleep, btn_awake, btn_feed, btn_play, btn_test;
   logic       cmd_sleep, cmd_awake, cmd_feed, cmd_play;
   logic       test_mode, test_valid, busy;
   logic [3:0] test_code;

   button_cmd_arbiter #(
      .HOLD_TEST(HOLD_TEST),
      .PULSE_WIN(PULSE_WIN),
      .LOCKOUT  (LOCKOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_sleep (btn_sleep),
      .btn_awake (btn_awake),
      .btn_feed  (btn_feed),
      .btn_play  (btn_play),
      .btn_test  (btn_test),
      .cmd_sleep (cmd_sleep),
      .cmd_awake (cmd_awake),
      .cmd_feed  (cmd_feed),
      .cmd_play  (cmd_play),
      .test_mode (test_mode),
      .test_code (test_code),
      .test_valid(test_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Command vector bits: 0 awake, 1 feed, 2 sleep, 3 play
   typedef struct {
      int         cyc;
      logic [3:0] cmd;
      logic       valid;
      logic [3:0] code;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int c, input logic [3:0] cmd, input logic v, input logic [3:0] code);
      exp_t e;
      e.cyc   = c;
      e.cmd   = cmd;
      e.valid = v;
      e.code  = code;
      exp_q.push_back(e);
   endtask

   task automatic monitor();
      logic [3:0] cmds;
      exp_t       e;
      forever begin
         @(negedge clk);
         cmds = {cmd_play, cmd_sleep, cmd_feed, cmd_awake};
         if (!rst && (cmds != 4'b0000 || test_valid)) begin
            check("event_exclusive", int'($countones(cmds)) + int'(test_valid), 1);
            if (exp_q.size() == 0) begin
               check("unexpected_event", int'({test_valid, cmds}), 0);
            end else begin
               e = exp_q.pop_front();
               check("event_cycle", cyc, e.cyc);
               check("event_cmd", int'(cmds), int'(e.cmd));
               check("event_valid", int'(test_valid), int'(e.valid));
               if (e.valid) check("event_code", int'(test_code), int'(e.code));
            end
         end
      end
   endtask

   // Long-press test; returns in the first cycle test_mode is seen
   task automatic enter_test();
      int t0;
      bit seen;
      btn_test = 1'b1;
      t0       = cyc;
      seen     = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick(1);
         if (test_mode) seen = 1'b1;
      end
      check("test_entry_cycle", seen ? cyc : -1, t0 + int'(HOLD_TEST) + 1);
      btn_test = 1'b0;
   endtask

   task automatic pulse_play(input int n, output int last);
      last = cyc;
      for (int i = 0; i < n; i++) begin
         btn_play = 1'b1;
         last     = cyc;
         tick(1);
         btn_play = 1'b0;
         tick(1);
      end
   endtask

   initial begin
      int p;
      rst       = 1'b1;
      btn_sleep = 1'b0;
      btn_awake = 1'b0;
      btn_feed  = 1'b0;
      btn_play  = 1'b0;
      btn_test  = 1'b0;
      fork
         monitor();
      join_none
      tick(3);
      check("rst_busy", int'(busy), 0);
      check("rst_mode", int'(test_mode), 0);
      check("rst_code", int'(test_code), 0);
      check("rst_cmds", int'({cmd_play, cmd_sleep, cmd_feed, cmd_awake, test_valid}), 0);
      rst = 1'b0;
      tick(2);
      check("idle_busy", int'(busy), 0);

      // Feed command, then a sleep edge inside the lockout is discarded
      btn_feed = 1'b1;
      push_exp(cyc + 1, 4'b0010, 1'b0, 4'd0);
      tick(3);
      check("lock_busy", int'(busy), 1);
      btn_sleep = 1'b1;
      tick(8);
      check("lock_done", int'(busy), 0);
      btn_feed  = 1'b0;
      btn_sleep = 1'b0;
      tick(2);

      // Simultaneous awake and play: awake wins
      btn_awake = 1'b1;
      btn_play  = 1'b1;
      push_exp(cyc + 1, 4'b0001, 1'b0, 4'd0);
      tick(8);
      btn_awake = 1'b0;
      btn_play  = 1'b0;
      tick(2);

      // Three code pulses commit code 3 after the window
      enter_test();
      pulse_play(3, p);
      check("code_accum3", int'(test_code), 3);
      check("mode_collect", int'(test_mode), 1);
      push_exp(p + int'(PULSE_WIN) + 1, 4'b0000, 1'b1, 4'd3);
      tick(p + int'(PULSE_WIN) + 1 - cyc);
      check("commit_mode", int'(test_mode), 0);
      check("commit_busy", int'(busy), 1);
      tick(int'(LOCKOUT));
      check("post_lock_busy", int'(busy), 1);
      tick(1);
      check("post_lock_idle", int'(busy), 0);
      check("code_held", int'(test_code), 3);

      // Twelve pulses saturate at 9
      enter_test();
      check("entry_code_clear", int'(test_code), 0);
      pulse_play(12, p);
      check("code_sat", int'(test_code), 9);
      push_exp(p + int'(PULSE_WIN) + 1, 4'b0000, 1'b1, 4'd9);
      tick(p + int'(PULSE_WIN) + int'(LOCKOUT) + 2 - cyc);
      check("sat_idle", int'(busy), 0);

      // Short press never enters test collection
      btn_test = 1'b1;
      tick(5);
      btn_test = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         check("short_hold_mode", int'(test_mode), 0);
      end
      check("short_hold_busy", int'(busy), 0);

      // Awake aborts collection without a commit or a command
      enter_test();
      pulse_play(2, p);
      check("code_accum2", int'(test_code), 2);
      btn_awake = 1'b1;
      tick(1);
      check("abort_code", int'(test_code), 0);
      check("abort_mode", int'(test_mode), 0);
      check("abort_busy", int'(busy), 0);
      btn_awake = 1'b0;
      tick(25);

      // Reset mid-collection with play held high
      enter_test();
      pulse_play(1, p);
      btn_play = 1'b1;
      rst      = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(3);
      check("rst_mid_outs", int'({cmd_play, cmd_sleep, cmd_feed, cmd_awake, test_valid, test_mode}), 0);
      check("rst_mid_code", int'(test_code), 0);
      check("rst_mid_busy", int'(busy), 0);
      btn_play = 1'b0;
      tick(25);
      check("rst_mid_idle", int'(busy), 0);

      tick(3);
      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
